// File: rtl/dmac_arb_pkg.sv
// Shared types for the AHB bus arbiter: HTRANS encoding, arbiter states and
// the transfer-activity helper.
package dmac_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_RELEASE
  } arb_state_t;

  // A beat that actually moves data: NONSEQ or SEQ.
  function automatic logic is_active(htrans_t t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate req so last+1 sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick
  import dmac_arb_pkg::*;
#(
  parameter int N    = 2,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic [IDXW-1:0] winner,
  output logic            found
);

  logic [N-1:0] rot;
  int           start;
  int           pos;

  always_comb begin
    start  = (int'(last) + 1) % N;
    rot    = '0;
    pos    = 0;
    for (int i = 0; i < N; i++) rot[i] = req[(start + i) % N];
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    found  = |rot;
    winner = IDXW'((pos + start) % N);
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB master-port arbiter with safe-point hand-over, beat-count
// preemption and data-phase owner tracking for the external HWDATA/HRDATA muxes.
//
// state     | meaning
// S_IDLE    | no owner; grant the round-robin winner of any request
// S_OWN     | owner granted; count beats, watch for drop or preemption
// S_RELEASE | grant removed; wait for the owner's bus to go IDLE, then hand over
module ahb_bus_arbiter
  import dmac_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int MAX_HOLD  = 16,
  parameter int IDXW      = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] lock,
  input  logic                 hready,
  input  logic [1:0]           owner_htrans,
  output logic [N_MASTERS-1:0] grant,
  output logic [IDXW-1:0]      owner,
  output logic                 owner_valid,
  output logic [IDXW-1:0]      data_owner,
  output logic                 data_owner_valid
);

  localparam int HOLDW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLDW-1:0] HOLD_MAX = HOLDW'(MAX_HOLD);

  arb_state_t           state, state_n;
  logic [HOLDW-1:0]     hold_cnt, hold_n;
  logic [IDXW-1:0]      last, last_n;
  logic [N_MASTERS-1:0] grant_n;
  logic [IDXW-1:0]      owner_n, data_owner_n;
  logic                 owner_valid_n, data_owner_valid_n;

  logic [IDXW-1:0]      winner;
  logic                 found;
  logic                 active;
  logic                 release_now;

  rr_pick #(.N(N_MASTERS), .IDXW(IDXW)) u_rr_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .found  (found)
  );

  assign active = is_active(htrans_t'(owner_htrans));

  // Preemption needs a competitor; a lone requester is never timed out.
  assign release_now = !req[owner] ||
                       ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && !lock[owner] &&
                        ((req & ~grant) != '0));

  always_comb begin
    state_n            = state;
    hold_n             = hold_cnt;
    last_n             = last;
    grant_n            = grant;
    owner_n            = owner;
    owner_valid_n      = owner_valid;
    data_owner_n       = data_owner;
    data_owner_valid_n = data_owner_valid;
    if (hready) begin
      data_owner_n       = owner;
      data_owner_valid_n = owner_valid && active;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            grant_n         = '0;
            grant_n[winner] = 1'b1;
            owner_n         = winner;
            owner_valid_n   = 1'b1;
            last_n          = winner;
            hold_n          = '0;
            state_n         = S_OWN;
          end
        end
        S_OWN: begin
          if (active && (hold_cnt != HOLD_MAX)) hold_n = hold_cnt + 1'b1;
          if (release_now) begin
            grant_n = '0;
            state_n = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (htrans_t'(owner_htrans) == IDLE) begin
            owner_valid_n = 1'b0;
            state_n       = S_IDLE;
            if (found) begin
              grant_n         = '0;
              grant_n[winner] = 1'b1;
              owner_n         = winner;
              owner_valid_n   = 1'b1;
              last_n          = winner;
              hold_n          = '0;
              state_n         = S_OWN;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      hold_cnt         <= '0;
      last             <= IDXW'(N_MASTERS - 1);
      grant            <= '0;
      owner            <= '0;
      owner_valid      <= 1'b0;
      data_owner       <= '0;
      data_owner_valid <= 1'b0;
    end else begin
      state            <= state_n;
      hold_cnt         <= hold_n;
      last             <= last_n;
      grant            <= grant_n;
      owner            <= owner_n;
      owner_valid      <= owner_valid_n;
      data_owner       <= data_owner_n;
      data_owner_valid <= data_owner_valid_n;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Randomized bench for ahb_bus_arbiter: a behavioural model predicts each
// cycle's outputs into a queue, a monitor pops and compares after every edge.
module tb_ahb_bus_arbiter;

  localparam int N    = 3;
  localparam int MAXH = 8;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  lock = '0;
  logic          hready = 1'b1;
  logic [1:0]    owner_htrans = 2'b00;
  logic [N-1:0]  grant;
  logic [IW-1:0] owner;
  logic          owner_valid;
  logic [IW-1:0] data_owner;
  logic          data_owner_valid;

  typedef struct {
    int grant;
    int owner;
    int ov;
    int downer;
    int dov;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   resets_done = 0;

  // Model: mode 0 = bus free, 1 = granted, 2 = draining after grant removal.
  int mode, m_owner, m_valid, m_last, m_beats, m_downer, m_dov;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(.N_MASTERS(N), .MAX_HOLD(MAXH), .IDXW(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .lock             (lock),
    .hready           (hready),
    .owner_htrans     (owner_htrans),
    .grant            (grant),
    .owner            (owner),
    .owner_valid      (owner_valid),
    .data_owner       (data_owner),
    .data_owner_valid (data_owner_valid)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) begin
      if (r[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  function automatic bit others_req(input logic [N-1:0] r, input int own);
    for (int i = 0; i < N; i++) begin
      if (i != own && r[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    mode = 0; m_owner = 0; m_valid = 0; m_last = N - 1;
    m_beats = 0; m_downer = 0; m_dov = 0;
  endtask

  task automatic take(input int w);
    mode = 1; m_owner = w; m_valid = 1; m_last = w; m_beats = 0;
  endtask

  task automatic model_step();
    bit act, rel;
    int w;
    exp_t e;
    act = (owner_htrans == 2'b10) || (owner_htrans == 2'b11);
    if (hready) begin
      m_downer = m_owner;
      m_dov    = m_valid && act;
      if (mode == 0) begin
        w = rr_winner(req, m_last);
        if (w >= 0) take(w);
      end else if (mode == 1) begin
        rel = !req[m_owner] ||
              (MAXH != 0 && m_beats == MAXH && !lock[m_owner] && others_req(req, m_owner));
        if (act && m_beats < MAXH) m_beats++;
        if (rel) mode = 2;
      end else if (owner_htrans == 2'b00) begin
        m_valid = 0;
        w = rr_winner(req, m_last);
        if (w >= 0) take(w);
        else mode = 0;
      end
    end
    e.grant  = (mode == 1) ? (1 << m_owner) : 0;
    e.owner  = m_owner;
    e.ov     = m_valid;
    e.downer = m_downer;
    e.dov    = m_dov;
    sb.push_back(e);
  endtask

  task automatic drive_cycle(input bit rnd);
    int r;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(23) == 0) req[i] = ~req[i];
        if ($urandom_range(39) == 0) lock[i] = ~lock[i];
      end
      hready = ($urandom_range(4) != 0);
      r = $urandom_range(9);
      owner_htrans = (r < 3) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
    end
    model_step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_owner_valid"}, owner_valid, 0);
    check({tag, "_data_owner"}, data_owner, 0);
    check({tag, "_data_owner_valid"}, data_owner_valid, 0);
  endtask

  // Reset lands between edges, so the outputs must clear without a clock.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    sb.delete();
    rst = 1'b0;
    model_reset();
    drive_cycle(1'b1);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("grant", grant, mon_e.grant);
      check("owner", owner, mon_e.owner);
      check("owner_valid", owner_valid, mon_e.ov);
      check("data_owner", data_owner, mon_e.downer);
      check("data_owner_valid", data_owner_valid, mon_e.dov);
    end
  end

  initial begin
    model_reset();
    rst = 1'b1;
    req = '1;
    hready = 1'b1;
    owner_htrans = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1'b0);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      drive_cycle(1'b1);
      if (resets_done < 3 && c > 900 * (resets_done + 1) && mode == 1 && m_beats >= 3) begin
        mid_reset();
        resets_done++;
      end
    end
    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Shares the single AHB master port between N requesting masters, for example the CPU and the DMAC (Bus_Req to Bus_Grant).
- Round-robin arbitration with hand-over only at safe AHB points.
- Optional beat-count preemption, so a long DMA transfer cannot starve the CPU.
- Also tracks the data-phase owner so the external HWDATA and HRDATA muxes stay aligned with the pipeline.

Parameters:
- N_MASTERS, 2: number of requesting masters (2 to 8).
- MAX_HOLD, 16: beats the owner may hold the bus while others wait; 0 disables preemption.
- IDXW, $clog2(N_MASTERS): width of the master index.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_MASTERS  per-master bus request (Bus_Req).
- lock  in  N_MASTERS  per-master lock; while the owner's lock=1, no preemption.
- hready  in  1  muxed HREADY from the slave side.
- owner_htrans  in  2  HTRANS of the current address-phase owner (muxed externally using owner).
- grant  out  N_MASTERS  one-hot bus grant (Bus_Grant).
- owner  out  IDXW  address-phase owner index.
- owner_valid  out  1  an owner exists.
- data_owner  out  IDXW  data-phase owner index.
- data_owner_valid  out  1  data phase belongs to a granted master.

Behaviour:
- Reset values: grant=0, owner=0, owner_valid=0, data_owner=0, data_owner_valid=0. Internal state: hold_cnt=0, last=N_MASTERS-1, state=S_IDLE.
- All outputs are registered.
- FSM S_IDLE:
  - If req!=0, pick the winner by round-robin, starting at last+1 mod N.
  - At the next edge: grant[w]=1, owner=w, owner_valid=1, last=w, hold_cnt=0, go to S_OWN.
  - Grant latency is 1 cycle from req.
- FSM S_OWN:
  - hold_cnt increments on each cycle with hready=1 and owner_htrans in {NONSEQ, SEQ}.
  - hold_cnt saturates at MAX_HOLD.
  - Release condition: req[owner]=0, OR (MAX_HOLD!=0, hold_cnt==MAX_HOLD, lock[owner]=0, and any other req asserted).
  - On release: grant goes to 0 at the next edge and the FSM enters S_RELEASE.
- FSM S_RELEASE:
  - owner and owner_valid are held.
  - Wait for hready=1 and owner_htrans==IDLE; the owner must finish or abandon its burst.
  - On that cycle: owner_valid drops at the next edge.
    - If any req is asserted, the winner is granted at the same edge (owner updated, hold_cnt=0, go to S_OWN). Otherwise go to S_IDLE.
  - If req[owner] reasserts while in S_RELEASE, it still competes only in round-robin. Last-granted has the lowest priority.
- Pipeline tracking: on every edge with hready=1, data_owner<=owner and data_owner_valid<=owner_valid and (owner_htrans in {NONSEQ, SEQ}). When hready=0, both hold.
- Simultaneous events:
  - A release and a new request in the same cycle resolve in that cycle's round-robin.
  - If hready=0, no grant change or hold_cnt change happens in that cycle.
- An owner dropping req in S_IDLE is not applicable. Only one-hot or zero grant is ever driven.
- A single requester with preemption due and no other req is never released by timeout.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous), regardless of state.

Decomposition:
- Package dmac_arb_pkg:
  - htrans_t enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - arb_state_t: S_IDLE, S_OWN, S_RELEASE.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: winner index, found.
  - Implemented by rotating req by last+1, priority-encoding, and rotating back.

Test Plan:
- Reset with req=2'b11 held → grant=0 and owner_valid=0 during rst. First edge after rst falls → grant=2'b01, owner=0.
- Single requester: req=2'b10 → grant=2'b10 one cycle later. Drop req with owner_htrans=IDLE and hready=1 → grant=0, then owner_valid=0 two edges after the drop.
- Both request, MAX_HOLD=8:
  - Master 0 is granted first.
  - After 8 NONSEQ/SEQ beats with hready=1, grant goes to 0.
  - When the owner drives IDLE, grant becomes 2'b10 on that edge. Master 1 then owns the bus and master 0 is next.
- Lock: same as above with lock[0]=1 → no preemption after 8 or 40 beats. Deassert lock → release on the next cycle.
- Stall: hready=0 for 5 cycles during S_RELEASE with owner_htrans=IDLE → no grant change and data_owner held. Hand-over occurs on the first hready=1 cycle.
- Reset mid-burst: assert rst while in S_OWN with hold_cnt=5 → all outputs go to 0 asynchronously. After release, round-robin restarts at master 0.
